// File: rtl/console_pkg.sv
// Shared types and constants for the UART text console.
package console_pkg;

    typedef enum logic [2:0] {
        S_WAIT_VM,
        S_IDLE,
        S_DECODE,
        S_LINE,
        S_CLEAR,
        S_HOLD
    } state_t;

    localparam int VM_ADDR_W  = 12;
    localparam int FILL_LEN_W = VM_ADDR_W + 1;

    localparam logic [FILL_LEN_W-1:0] LINE_LEN   = 13'd64;
    localparam logic [FILL_LEN_W-1:0] SCREEN_LEN = 13'd4096;

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_SP = 8'h20;

    // Row increment with explicit wrap at the last visible row.
    function automatic logic [5:0] row_inc(input logic [5:0] row, input logic [5:0] row_max);
        return (row == row_max) ? 6'd0 : row + 6'd1;
    endfunction

endpackage

// File: rtl/console_fill.sv
// Fill engine: streams one address per cycle from a start address for a
// given length; used for both single-line and full-screen clears.
module console_fill
    import console_pkg::*;
#(
    parameter logic [7:0] FILL_CHAR = CH_SP
) (
    input  logic                  clk,
    input  logic                  reset_p,
    input  logic                  start,
    input  logic                  abort,
    input  logic [VM_ADDR_W-1:0]  base,
    input  logic [FILL_LEN_W-1:0] len,
    output logic [VM_ADDR_W-1:0]  addr,
    output logic [7:0]            data,
    output logic                  valid,
    output logic                  last
);

    logic [FILL_LEN_W-1:0] remaining;

    assign data = FILL_CHAR;
    assign last = valid && (remaining == 13'd1);

    // Address counter: load on start, advance once per cycle until the length is spent.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            valid     <= 1'b0;
            addr      <= '0;
            remaining <= '0;
        end else if (start) begin
            valid     <= 1'b1;
            addr      <= base;
            remaining <= len;
        end else if (valid) begin
            if (abort || remaining == 13'd1) begin
                valid <= 1'b0;
            end else begin
                addr      <= addr + 12'd1;
                remaining <= remaining - 13'd1;
            end
        end
    end

endmodule

// File: rtl/uart_text_console.sv
// UART receive consumer that renders bytes as text into video memory,
// with cursor tracking, CR/LF/BS/FF handling and line/screen clearing.
module uart_text_console
    import console_pkg::*;
#(
    parameter int         ROWS      = 48,
    parameter int         COLS      = 64,
    parameter logic [7:0] FILL_CHAR = CH_SP
) (
    input  logic                 clk,
    input  logic                 reset_p,
    input  logic                 rx_full,
    input  logic [7:0]           rx_data,
    input  logic                 rx_ovr,
    output logic                 rx_rd,
    input  logic                 vm_reset_done,
    output logic [VM_ADDR_W-1:0] vm_w_addr,
    output logic [7:0]           vm_w_data,
    output logic                 vm_w_valid,
    output logic [5:0]           cursor_row,
    output logic [5:0]           cursor_col,
    output logic                 busy,
    output logic [7:0]           ovr_count
);

    localparam logic [5:0] ROW_MAX = 6'(ROWS - 1);
    localparam logic [5:0] COL_MAX = 6'(COLS - 1);

    state_t                 state_q, state_d;
    logic [7:0]             byte_q;
    logic                   ovr_q;

    logic [5:0]             row_d, col_d, col_m1;
    logic                   rd_d, byte_load, newline;
    logic                   wr_en;
    logic [VM_ADDR_W-1:0]   wr_addr;
    logic [7:0]             wr_data;

    logic                   fill_start, fill_abort;
    logic [VM_ADDR_W-1:0]   fill_base;
    logic [FILL_LEN_W-1:0]  fill_len;
    logic [VM_ADDR_W-1:0]   fill_addr;
    logic [7:0]             fill_data;
    logic                   fill_valid, fill_last;

    assign col_m1 = cursor_col - 6'd1;

    console_fill #(.FILL_CHAR(FILL_CHAR)) u_fill (
        .clk     (clk),
        .reset_p (reset_p),
        .start   (fill_start),
        .abort   (fill_abort),
        .base    (fill_base),
        .len     (fill_len),
        .addr    (fill_addr),
        .data    (fill_data),
        .valid   (fill_valid),
        .last    (fill_last)
    );

    // State register.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) state_q <= S_WAIT_VM;
        else         state_q <= state_d;
    end

    // Next-state, cursor update and write/fill requests.
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        row_d      = cursor_row;
        col_d      = cursor_col;
        rd_d       = 1'b0;
        byte_load  = 1'b0;
        newline    = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        fill_start = 1'b0;
        fill_abort = 1'b0;
        fill_base  = '0;
        fill_len   = '0;

        case (state_q)
            S_WAIT_VM: if (vm_reset_done) state_d = S_IDLE;

            S_IDLE: begin
                if (!vm_reset_done) begin
                    state_d = S_WAIT_VM;
                end else if (rx_full) begin
                    byte_load = 1'b1;
                    rd_d      = 1'b1;
                    state_d   = S_DECODE;
                end
            end

            S_DECODE: begin
                state_d = S_HOLD;
                if (byte_q >= 8'h20 && byte_q <= 8'h7E) begin
                    wr_en   = 1'b1;
                    wr_addr = {cursor_row, cursor_col};
                    wr_data = byte_q;
                    if (cursor_col == COL_MAX) begin
                        col_d   = 6'd0;
                        newline = 1'b1;
                    end else begin
                        col_d = cursor_col + 6'd1;
                    end
                end else begin
                    case (byte_q)
                        CH_CR: col_d = 6'd0;
                        CH_LF: newline = 1'b1;
                        CH_BS: begin
                            if (cursor_col != 6'd0) begin
                                col_d   = col_m1;
                                wr_en   = 1'b1;
                                wr_addr = {cursor_row, col_m1};
                                wr_data = FILL_CHAR;
                            end
                        end
                        CH_FF: begin
                            fill_start = 1'b1;
                            fill_base  = '0;
                            fill_len   = SCREEN_LEN;
                            state_d    = S_CLEAR;
                        end
                        default: ;
                    endcase
                end
                if (newline) begin
                    row_d      = row_inc(cursor_row, ROW_MAX);
                    fill_start = 1'b1;
                    fill_base  = {row_d, 6'd0};
                    fill_len   = LINE_LEN;
                    state_d    = S_LINE;
                end
            end

            S_LINE, S_CLEAR: begin
                wr_en   = fill_valid;
                wr_addr = fill_addr;
                wr_data = fill_data;
                if (!vm_reset_done) begin
                    fill_abort = 1'b1;
                    state_d    = S_WAIT_VM;
                end else if (fill_last) begin
                    state_d = S_HOLD;
                    if (state_q == S_CLEAR) begin
                        row_d = 6'd0;
                        col_d = 6'd0;
                    end
                end
            end

            S_HOLD: state_d = vm_reset_done ? S_IDLE : S_WAIT_VM;

            default: state_d = S_WAIT_VM;
        endcase
    end

    // Registered outputs, cursor and received byte.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            rx_rd      <= 1'b0;
            vm_w_valid <= 1'b0;
            vm_w_addr  <= '0;
            vm_w_data  <= '0;
            cursor_row <= 6'd0;
            cursor_col <= 6'd0;
            busy       <= 1'b1;
            byte_q     <= '0;
        end else begin
            rx_rd      <= rd_d;
            vm_w_valid <= wr_en;
            if (wr_en) begin
                vm_w_addr <= wr_addr;
                vm_w_data <= wr_data;
            end
            cursor_row <= row_d;
            cursor_col <= col_d;
            busy       <= (state_d != S_IDLE);
            if (byte_load) byte_q <= rx_data;
        end
    end

    // Saturating count of rx_ovr rising edges.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            ovr_q     <= 1'b0;
            ovr_count <= 8'd0;
        end else begin
            ovr_q <= rx_ovr;
            if (rx_ovr && !ovr_q && ovr_count != 8'hFF) ovr_count <= ovr_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_uart_text_console.sv
// Self-checking bench for uart_text_console: expected video-memory writes
// are queued at stimulus time and popped by an independent write monitor.
module tb_uart_text_console;

    logic        clk = 1'b0;
    logic        reset_p = 1'b1;
    logic        rx_full = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ovr = 1'b0;
    logic        rx_rd;
    logic        vm_reset_done = 1'b0;
    logic [11:0] vm_w_addr;
    logic [7:0]  vm_w_data;
    logic        vm_w_valid;
    logic [5:0]  cursor_row, cursor_col;
    logic        busy;
    logic [7:0]  ovr_count;

    int n_checks = 0;
    int n_pass   = 0;
    int rd_pulses = 0;
    int n_sent   = 0;
    logic [19:0] exp_q[$];

    localparam int IDLE_BOUND = 6000;

    uart_text_console dut (
        .clk           (clk),
        .reset_p       (reset_p),
        .rx_full       (rx_full),
        .rx_data       (rx_data),
        .rx_ovr        (rx_ovr),
        .rx_rd         (rx_rd),
        .vm_reset_done (vm_reset_done),
        .vm_w_addr     (vm_w_addr),
        .vm_w_data     (vm_w_data),
        .vm_w_valid    (vm_w_valid),
        .cursor_row    (cursor_row),
        .cursor_col    (cursor_col),
        .busy          (busy),
        .ovr_count     (ovr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        $display("FAIL %s: timed out", name);
    endtask

    // Write monitor: every observed write must match the head of the queue.
    always @(negedge clk) begin
        if (!reset_p && vm_w_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none", vm_w_addr, vm_w_data);
            end else begin
                check("vm_write", {12'h0, vm_w_addr, vm_w_data}, {12'h0, exp_q.pop_front()});
            end
        end
        if (rx_rd) rd_pulses++;
    end

    task automatic push_w(input logic [11:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic push_fill(input logic [11:0] base, input int len);
        for (int i = 0; i < len; i++) push_w(12'(base + 12'(i)), 8'h20);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < IDLE_BOUND) begin @(negedge clk); n++; end
        if (busy) fail_timeout("wait_idle");
    endtask

    // Present one byte, expect rx_rd on the next cycle, then wait for completion.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        wait_idle();
        rx_data = b;
        rx_full = 1'b1;
        n_sent++;
        do begin @(negedge clk); n++; end while (!rx_rd && n < 20);
        check("rx_rd_latency", n, 1);
        rx_full = 1'b0;
        wait_idle();
    endtask

    task automatic check_cursor(input string name, input int r, input int c);
        check({name, "_row"}, {26'h0, cursor_row}, r);
        check({name, "_col"}, {26'h0, cursor_col}, c);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_rx_rd"}, {31'h0, rx_rd}, 0);
        check({name, "_vm_w_valid"}, {31'h0, vm_w_valid}, 0);
        check({name, "_vm_w_addr"}, {20'h0, vm_w_addr}, 0);
        check({name, "_vm_w_data"}, {24'h0, vm_w_data}, 0);
        check_cursor(name, 0, 0);
        check({name, "_ovr_count"}, {24'h0, ovr_count}, 0);
        check({name, "_busy"}, {31'h0, busy}, 1);
    endtask

    initial begin
        int n;
        int busy_cycles;

        // Reset values, then hold in S_WAIT_VM while video memory initialises.
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_p = 1'b0;
        repeat (4) @(negedge clk);
        check("wait_vm_busy", {31'h0, busy}, 1);
        vm_reset_done = 1'b1;
        wait_idle();

        // "AB"
        push_w(12'h000, 8'h41);
        send_byte(8'h41);
        push_w(12'h001, 8'h42);
        send_byte(8'h42);
        check_cursor("ab", 0, 2);
        check("ab_rd_pulses", rd_pulses, 2);

        // CR back to column 0, then 64 'x' with autowrap and line clear.
        send_byte(8'h0D);
        check_cursor("cr", 0, 0);
        for (int i = 0; i < 64; i++) begin
            push_w(12'(i), 8'h78);
            if (i == 63) push_fill(12'h040, 64);
            send_byte(8'h78);
        end
        check_cursor("autowrap", 1, 0);

        // Walk down to row 47, move to column 5, then LF wraps to row 0.
        for (int r = 2; r <= 47; r++) begin
            push_fill({6'(r), 6'd0}, 64);
            send_byte(8'h0A);
        end
        for (int i = 0; i < 5; i++) begin
            push_w({6'd47, 6'(i)}, 8'(8'h61 + i));
            send_byte(8'(8'h61 + i));
        end
        check_cursor("row47", 47, 5);
        push_fill(12'h000, 64);
        send_byte(8'h0A);
        check_cursor("lf_wrap", 0, 5);

        // Backspace at column 0 is a no-op; otherwise it blanks the previous cell.
        send_byte(8'h0D);
        for (int r = 1; r <= 3; r++) begin
            push_fill({6'(r), 6'd0}, 64);
            send_byte(8'h0A);
        end
        send_byte(8'h08);
        check_cursor("bs_col0", 3, 0);
        for (int i = 0; i < 4; i++) begin
            push_w({6'd3, 6'(i)}, 8'(8'h31 + i));
            send_byte(8'(8'h31 + i));
        end
        push_w(12'h0C3, 8'h20);
        send_byte(8'h08);
        check_cursor("bs", 3, 3);
        send_byte(8'h01);
        send_byte(8'h7F);
        check_cursor("discard", 3, 3);

        // Form feed: full clear, busy throughout, three rx_ovr pulses on the way.
        push_fill(12'h000, 4096);
        rx_data = 8'h0C;
        rx_full = 1'b1;
        n_sent++;
        n = 0;
        do begin @(negedge clk); n++; end while (!rx_rd && n < 20);
        check("ff_rx_rd_latency", n, 1);
        rx_full = 1'b0;
        busy_cycles = 0;
        n = 0;
        while (busy && n < IDLE_BOUND) begin
            @(negedge clk);
            n++;
            rx_ovr = (n == 100 || n == 300 || n == 500);
            if (busy) busy_cycles++;
        end
        rx_ovr = 1'b0;
        if (busy) fail_timeout("clear_done");
        check("clear_busy_cycles", busy_cycles, 4097);
        check("clear_pending", exp_q.size(), 0);
        check_cursor("clear", 0, 0);
        check("ovr_count_3", {24'h0, ovr_count}, 3);

        // Reset in the middle of a clear.
        push_fill(12'h000, 4096);
        rx_data = 8'h0C;
        rx_full = 1'b1;
        n_sent++;
        @(negedge clk);
        rx_full = 1'b0;
        repeat (50) @(negedge clk);
        #2 reset_p = 1'b1;
        vm_reset_done = 1'b0;
        #1 check_reset_outputs("mid_clear_reset");
        exp_q.delete();
        @(negedge clk);
        reset_p = 1'b0;
        repeat (5) @(negedge clk);
        check("post_reset_wait_vm", {31'h0, busy}, 1);
        vm_reset_done = 1'b1;
        wait_idle();
        push_w(12'h000, 8'h5A);
        send_byte(8'h5A);
        check_cursor("post_reset", 0, 1);

        // ovr_count saturation.
        for (int i = 0; i < 260; i++) begin
            rx_ovr = 1'b1;
            @(negedge clk);
            rx_ovr = 1'b0;
            @(negedge clk);
        end
        check("ovr_saturate", {24'h0, ovr_count}, 8'hFF);

        check("final_pending", exp_q.size(), 0);
        check("rd_pulses_total", rd_pulses, n_sent);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
